// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opr1;
    logic [WIDTH-1:0] opr2;
    logic [1:0]       write_opt;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, opr1, opr2, write_opt, write_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, opr1, opr2, write_opt, write_data,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// HI/LO arithmetic unit: pipelined signed/unsigned multiply and iterative
// restoring signed/unsigned divide, with direct software writes to HI/LO.
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PW      = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_DIV_ITER = 2'd2,
        ST_DIV_FIX  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pipe_q [MUL_LATENCY];
    logic [PW-1:0]    pipe_d [MUL_LATENCY];
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Datapath helpers: operand extension, product, magnitudes, divider step, sign fix-up.
    logic             mul_signed_s;
    logic             div_signed_s;
    logic [PW-1:0]    mul_a_s, mul_b_s, product_s;
    logic [WIDTH-1:0] abs1_s, abs2_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

    // Combinational arithmetic feeding the state update.
    always_comb begin
        mul_signed_s = (bus.op == 2'b00);
        div_signed_s = (bus.op == 2'b10);
        mul_a_s      = mul_signed_s ? {{WIDTH{bus.opr1[WIDTH-1]}}, bus.opr1}
                                    : {{WIDTH{1'b0}}, bus.opr1};
        mul_b_s      = mul_signed_s ? {{WIDTH{bus.opr2[WIDTH-1]}}, bus.opr2}
                                    : {{WIDTH{1'b0}}, bus.opr2};
        product_s    = mul_a_s * mul_b_s;
        abs1_s       = (div_signed_s && bus.opr1[WIDTH-1]) ? (~bus.opr1 + WIDTH'(1)) : bus.opr1;
        abs2_s       = (div_signed_s && bus.opr2[WIDTH-1]) ? (~bus.opr2 + WIDTH'(1)) : bus.opr2;
        // Partial remainder stays below the divisor, so the W-bit difference is exact.
        shifted_s    = {rem_q, quo_q[WIDTH-1]};
        ge_s         = (shifted_s >= {1'b0, dvs_q});
        diff_s       = shifted_s[WIDTH-1:0] - dvs_q;
        quo_fix_s    = quo_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix_s    = rem_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
    end

    // Next-state logic: direct writes first, then FSM; a completion overrides any write.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pipe_d     = pipe_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        dividend_d = dividend_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (bus.write_opt[0]) begin
            lo_d = bus.write_data;
        end else begin
            lo_d = lo_q;
        end
        if (bus.write_opt[1]) begin
            hi_d = bus.write_data;
        end else begin
            hi_d = hi_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.op[1]) begin
                        state_d    = ST_DIV_ITER;
                        cnt_d      = CNT_W'(WIDTH - 1);
                        quo_d      = abs1_s;
                        rem_d      = '0;
                        dvs_d      = abs2_s;
                        dividend_d = bus.opr1;
                        quo_neg_d  = div_signed_s && (bus.opr1[WIDTH-1] ^ bus.opr2[WIDTH-1]);
                        rem_neg_d  = div_signed_s && bus.opr1[WIDTH-1];
                        div_zero_d = (bus.opr2 == '0);
                    end else begin
                        state_d   = ST_MUL;
                        cnt_d     = CNT_W'(MUL_LATENCY - 1);
                        pipe_d[0] = product_s;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_MUL: begin
                for (int i = 1; i < MUL_LATENCY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = pipe_q[MUL_LATENCY-1];
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV_ITER: begin
                quo_d = {quo_q[WIDTH-2:0], ge_s};
                rem_d = ge_s ? diff_s : shifted_s[WIDTH-1:0];
                if (cnt_q == '0) begin
                    state_d = ST_DIV_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV_FIX: begin
                if (div_zero_q) begin
                    lo_d = '1;
                    hi_d = dividend_q;
                end else begin
                    lo_d = quo_fix_s;
                    hi_d = rem_fix_s;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset discarding any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            dividend_q <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pipe_q     <= pipe_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            dividend_q <= dividend_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: transaction-level reference model compared every cycle,
// directed corner cases with literal expectations, then randomized traffic.
module tb_muldiv_unit;
    localparam int W       = 32;
    localparam int LAT     = 4;
    localparam int DIV_LAT = W + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .MUL_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {hi, lo} an operation must produce, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, rm;
        longint unsigned ua, ub, uq, urm;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 64'd0;
        case (o)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            2'b10: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    uq  = ua / ub;
                    urm = ua % ub;
                    r   = {urm[31:0], uq[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Reference model state.
    logic [W-1:0]   m_hi, m_lo;
    logic           m_busy, m_done;
    int             m_left;
    logic [2*W-1:0] m_res;

    // Model: writes apply every edge; an accepted op completes after its latency and wins.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (bus.write_opt[0]) m_lo <= bus.write_data;
            if (bus.write_opt[1]) m_hi <= bus.write_data;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (bus.start) begin
                m_res  <= ref_result(bus.op, bus.opr1, bus.opr2);
                m_left <= bus.op[1] ? DIV_LAT : LAT;
                m_busy <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            chk("hi",   64'(bus.hi),   64'(m_hi));
            chk("lo",   64'(bus.lo),   64'(m_lo));
            chk("busy", 64'(bus.busy), 64'(m_busy));
            chk("done", 64'(bus.done), 64'(m_done));
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            4:       v = 32'd0 - 32'($urandom_range(1, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op at the current negedge, optionally write or re-poke start while busy,
    // and check busy duration and the final HI/LO against literal expectations.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input int wr_at, input logic [1:0] wr_opt, input logic [31:0] wr_data,
                          input bit poke, input string nm);
        int nb;
        bit seen;
        nb   = 0;
        seen = 1'b0;
        bus.start = 1'b1;
        bus.op    = o;
        bus.opr1  = a;
        bus.opr2  = b;
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) nb++;
            if (wr_at >= 0 && i == wr_at + 1 && wr_opt[1]) begin
                chk({nm, "_midwrite_hi"}, 64'(bus.hi), 64'(wr_data));
            end
            bus.start      = poke && (i == 2);
            bus.op         = 2'($urandom);
            bus.opr1       = $urandom;
            bus.opr2       = $urandom;
            bus.write_opt  = (i == wr_at) ? wr_opt : 2'b00;
            bus.write_data = wr_data;
            @(negedge clk);
        end
        bus.start     = 1'b0;
        bus.write_opt = 2'b00;
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        chk({nm, "_busy_cycles"}, 64'(nb), 64'(lat));
        chk({nm, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({nm, "_lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.op         = 2'b00;
        bus.opr1       = '0;
        bus.opr2       = '0;
        bus.write_opt  = 2'b00;
        bus.write_data = '0;
        rst = 1'b1;
        #3;
        chk("reset_hi",   64'(bus.hi),   64'd0);
        chk("reset_lo",   64'(bus.lo),   64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Direct writes in IDLE.
        bus.write_opt  = 2'b10;
        bus.write_data = 32'hCAFE_0000;
        @(negedge clk);
        bus.write_opt  = 2'b01;
        bus.write_data = 32'h0000_1234;
        @(negedge clk);
        bus.write_opt  = 2'b00;
        chk("wr_idle_lo", 64'(bus.lo), 64'h1234);
        chk("wr_idle_hi", 64'(bus.hi), 64'hCAFE_0000);

        // Model pins: literal expectations for the reference function itself.
        chk("ref_divs_ovf", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("ref_divs_neg", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT, -1, 2'b00, 32'd0, 1'b0, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, LAT, -1, 2'b00, 32'd0, 1'b0, "mult_m1");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, -1, 2'b00, 32'd0, 1'b0, "div_m7_2");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, DIV_LAT, -1, 2'b00, 32'd0, 1'b0, "divu_big_2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT, -1, 2'b00, 32'd0, 1'b0, "div_ovf");
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT, -1, 2'b00, 32'd0, 1'b0, "divu_by0");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT, -1, 2'b00, 32'd0, 1'b0, "div_by0");
        run_op(2'b00, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT, 1, 2'b10, 32'hDEAD_BEEF, 1'b0, "mult_wr_mid");
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, LAT, 3, 2'b11, 32'h5555_5555, 1'b0, "multu_wr_last");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, -1, 2'b00, 32'd0, 1'b1, "divu_poke");
        run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, LAT, -1, 2'b00, 32'd0, 1'b0, "b2b_multu");

        // Asynchronous reset in the middle of a divide.
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.opr1  = 32'd1000;
        bus.opr2  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_hi",   64'(bus.hi),   64'd0);
        chk("rst_mid_lo",   64'(bus.lo),   64'd0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, DIV_LAT, -1, 2'b00, 32'd0, 1'b0, "div_after_rst");

        // Randomized traffic checked by the per-cycle compare process.
        for (int c = 0; c < 1500; c++) begin
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.op         = 2'($urandom);
            bus.opr1       = pick();
            bus.opr2       = pick();
            bus.write_opt  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
            bus.write_data = $urandom;
            @(negedge clk);
        end
        bus.start     = 1'b0;
        bus.write_opt = 2'b00;
        for (int c = 0; c < 60; c++) begin
            if (bus.busy !== 1'b1) break;
            @(negedge clk);
        end
        chk("drain_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
